cc_packet_tx: RTL and testbench
===============================

CC_PACKET_TX -- requirements
Module: cc_packet_tx

Interface
REQ-001 SHALL have parameter PKT_BYTES, default 2048: payload bytes per packet (512 words x 4 bytes), range 1..4096.
REQ-002 SHALL have parameter BAUD_DIV, default 16: clocks per serial bit, minimum 4.
REQ-003 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port RDY, input, 1: frame-ready request from the frame assembler; rising edge starts a packet.
REQ-006 SHALL have port rdaddress, output, 12: byte address into the frame RAM.
REQ-007 SHALL have port data, input, 8: frame RAM byte, valid 1 clock after rdaddress changes.
REQ-008 SHALL have port tx, output, 1: UART 8N1 serial line, LSB first, idle high.
REQ-009 SHALL have port busy, output, 1: high while a packet is being sent.
REQ-010 SHALL have port done, output, 1: one-clock pulse when the last stop bit ends.
REQ-011 SHALL have port overrun, output, 1: sticky flag for a RDY edge that arrived while busy.

Function
REQ-012 SHALL register RDY and detect a rising edge (RDY=1, previous=0); a level held high starts exactly one packet.
REQ-013 SHALL send a packet as SYNC0=0xFF, SYNC1=0x00, SEQ, payload bytes at RAM addresses 0..PKT_BYTES-1 in order, then CSUM, for PKT_BYTES+4 bytes total.
REQ-014 SHALL compute CSUM as the 8-bit sum, mod 256, of the payload bytes only.
REQ-015 SHALL set SEQ to 0 after reset, increment it by 1 after each completed packet, and wrap 255->0.
REQ-016 SHALL frame each byte as start bit 0, 8 data bits LSB first, then stop bit 1, each bit held exactly BAUD_DIV clocks.
REQ-017 SHALL send bytes back to back with no idle gap; packet length is exactly (PKT_BYTES+4)*10*BAUD_DIV clocks.
REQ-018 SHALL drive tx low for the first start bit and raise busy in the clock after the RDY edge is detected.
REQ-019 SHALL present the next payload address and latch data, including the CSUM update, during the current byte's stop bit, so the next start bit is not delayed.
REQ-020 SHALL use the state machine IDLE -> SYNC0 -> SYNC1 -> SEQ -> PAYLOAD (repeat PKT_BYTES times) -> CSUM -> DONE -> IDLE; DONE lasts 1 clock, asserts done, clears busy and returns rdaddress to 0.
REQ-021 SHALL ignore any RDY edge while busy=1 or in DONE and set overrun=1; overrun clears only on reset.
REQ-022 SHALL accept a RDY edge in the first clock back in IDLE.
REQ-023 SHALL use a 12-bit payload byte counter that stops at PKT_BYTES-1; a value of 4096 ends on the final address without wrap errors.

Reset
REQ-024 SHALL, while reset=0 at a clock edge, force tx=1, busy=0, done=0, overrun=0, rdaddress=0, SEQ=0, CSUM=0 and state IDLE.
REQ-025 SHALL abort a packet in progress when reset is asserted, with tx high from the next clock; no partial byte is resumed after reset.
REQ-026 SHALL ignore RDY in the first clock after reset release, initialising the edge register to the sampled RDY.

Structure
REQ-027 SHALL place SYNC0, SYNC1, ADDR_W=12 and the state encoding in shared package cc_pkg.
REQ-028 SHALL implement the start/data/stop bit timing in sub-module cc_byte_ser (load strobe, 8-bit byte, tx, byte_end pulse); the packet FSM in cc_packet_tx sequences the bytes.

Verification
REQ-029 SHALL cover: PKT_BYTES=4, BAUD_DIV=4, RAM 01 02 03 04, RDY pulse -> tx bytes FF 00 00 01 02 03 04 0A, busy high 320 clocks, done 1 clock.
REQ-030 SHALL cover: RAM FF FF 02 00 -> CSUM 0x00 (wrap), SEQ 0x01 on the second packet.
REQ-031 SHALL cover: second RDY pulse 100 clocks into a packet -> only one packet sent, overrun=1 until reset.
REQ-032 SHALL cover: RDY held high for 1000 clocks -> exactly one packet.
REQ-033 SHALL cover: 257 packets -> SEQ sequence 00..FF then 00.
REQ-034 SHALL cover: reset=0 at clock 150 of a packet -> tx=1 and busy=0 next clock; the next packet carries SEQ 00.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared constants and packet FSM state encoding for the packet transmitter.
package cc_pkg;

  // Width of the frame RAM byte address.
  localparam int ADDR_W = 12;

  // Two-byte preamble that lets the receiver find the start of a packet.
  localparam logic [7:0] SYNC0 = 8'hFF;
  localparam logic [7:0] SYNC1 = 8'h00;

  // Packet sequencer states, in transmission order.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC0   = 3'd1,
    ST_SYNC1   = 3'd2,
    ST_SEQ     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/cc_byte_ser.sv
// UART 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit,
// each bit held for BAUD_DIV clocks. The line idles high.
//
// Handshake: 'load' is a one-clock strobe that captures 'value' and starts
// the start bit on the next clock. The owner may pulse 'load' while the
// serializer is idle, or in the same clock that 'byte_end' is high (the last
// clock of the stop bit), which gives back-to-back bytes with no idle gap.
// 'byte_end' is a combinational one-clock pulse.
module cc_byte_ser #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic       tx,
  output logic       byte_end
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    shreg;
  logic          running;

  assign byte_end = running && (baud_cnt == BAUD_LAST) && (bit_idx == 4'd9);

  // Bit timing and line drive; a load always restarts at a fresh start bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx       <= 1'b1;
      running  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else if (load) begin
      tx       <= 1'b0;
      running  <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= value;
    end else if (running) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          running <= 1'b0;
          tx      <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'd8) tx <= 1'b1;
          else                 tx <= shreg[bit_idx[2:0]];
        end
      end else begin
        baud_cnt <= baud_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cc_packet_tx.sv
// Packet transmitter: on a RDY rising edge sends SYNC0, SYNC1, SEQ, the
// payload bytes read from the frame RAM, then an 8-bit additive checksum,
// all back to back over a UART 8N1 line.
module cc_packet_tx import cc_pkg::*; #(
  parameter int PKT_BYTES = 2048,
  parameter int BAUD_DIV  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RDY,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [7:0]        data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output state_t            fsm_state
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PKT_BYTES - 1);

  state_t            state;
  state_t            state_next;
  logic              rdy_q;
  logic              rdy_edge;
  logic              ser_load;
  logic [7:0]        ser_value;
  logic              byte_end;
  logic [7:0]        seq;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] byte_cnt;   // index of the payload byte on the line
  logic              last_byte;

  assign rdy_edge  = RDY && !rdy_q;
  assign last_byte = (byte_cnt == LAST);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);
  assign fsm_state = state;

  cc_byte_ser #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (ser_load),
    .value    (ser_value),
    .tx       (tx),
    .byte_end (byte_end)
  );

  // Packet state register.
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and the byte handed to the serializer at each byte boundary.
  always_comb begin
    state_next = state;
    ser_load   = 1'b0;
    ser_value  = SYNC0;
    case (state)
      ST_IDLE: begin
        if (rdy_edge) begin
          ser_load   = 1'b1;
          ser_value  = SYNC0;
          state_next = ST_SYNC0;
        end
      end
      ST_SYNC0: begin
        if (byte_end) begin
          ser_load   = 1'b1;
          ser_value  = SYNC1;
          state_next = ST_SYNC1;
        end
      end
      ST_SYNC1: begin
        if (byte_end) begin
          ser_load   = 1'b1;
          ser_value  = seq;
          state_next = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (byte_end) begin
          ser_load   = 1'b1;
          ser_value  = data;
          state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_end) begin
          ser_load = 1'b1;
          if (last_byte) begin
            ser_value  = csum;
            state_next = ST_CSUM;
          end else begin
            ser_value  = data;
          end
        end
      end
      ST_CSUM: begin
        if (byte_end) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // RDY edge register, sequence number, checksum, RAM address prefetch and
  // the sticky overrun flag. The RAM address always runs one byte ahead of
  // the byte being loaded and saturates on the final payload address.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rdy_q     <= RDY;
      seq       <= '0;
      csum      <= '0;
      byte_cnt  <= '0;
      rdaddress <= '0;
      overrun   <= 1'b0;
    end else begin
      rdy_q <= RDY;
      if (rdy_edge && (state != ST_IDLE)) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rdy_edge) begin
            csum     <= '0;
            byte_cnt <= '0;
          end
        end
        ST_SEQ: begin
          if (byte_end) begin
            csum     <= data;
            byte_cnt <= '0;
            if (rdaddress != LAST) rdaddress <= rdaddress + ADDR_W'(1);
          end
        end
        ST_PAYLOAD: begin
          if (byte_end && !last_byte) begin
            csum     <= csum + data;
            byte_cnt <= byte_cnt + ADDR_W'(1);
            if (rdaddress != LAST) rdaddress <= rdaddress + ADDR_W'(1);
          end
        end
        ST_CSUM: begin
          if (byte_end) seq <= seq + 8'd1;
        end
        ST_DONE: begin
          rdaddress <= '0;
          byte_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_packet_tx.sv
// Bench for cc_packet_tx: a UART line decoder turns tx back into bytes and a
// packet-level model builds the expected byte list from the RAM contents.
module tb_cc_packet_tx;
  import cc_pkg::*;

  localparam int PB         = 4;
  localparam int BD         = 4;
  localparam int PKT_CLKS   = (PB + 4) * 10 * BD;
  localparam int PKT_CLKS_S = (1 + 4) * 10 * BD;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic rst_q;
  always @(posedge clock) rst_q <= reset;

  // main instance: 4-byte payload
  logic              rdy;
  logic [ADDR_W-1:0] rdaddress;
  logic [7:0]        data;
  logic              tx, busy, done, overrun;
  state_t            fsm_state;
  logic [7:0]        ram [PB];

  cc_packet_tx #(.PKT_BYTES(PB), .BAUD_DIV(BD)) u_dut (
    .clock(clock), .reset(reset), .RDY(rdy), .rdaddress(rdaddress),
    .data(data), .tx(tx), .busy(busy), .done(done), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  always @(posedge clock)
    data <= (rdaddress < ADDR_W'(PB)) ? ram[int'(rdaddress)] : 8'hxx;

  // second instance: 1-byte payload, used for the long sequence-number run
  logic              rdy_s;
  logic [ADDR_W-1:0] rdaddress_s;
  logic [7:0]        data_s;
  logic              tx_s, busy_s, done_s, overrun_s;
  state_t            fsm_state_s;
  logic [7:0]        ram_s;

  cc_packet_tx #(.PKT_BYTES(1), .BAUD_DIV(BD)) u_dut_s (
    .clock(clock), .reset(reset), .RDY(rdy_s), .rdaddress(rdaddress_s),
    .data(data_s), .tx(tx_s), .busy(busy_s), .done(done_s),
    .overrun(overrun_s), .fsm_state(fsm_state_s)
  );

  always @(posedge clock)
    data_s <= (rdaddress_s == '0) ? ram_s : 8'hxx;

  // line decoders (channel 0 = main, 1 = second), sampled mid-bit
  logic [7:0] got_q[$];
  logic [7:0] got_s_q[$];
  logic [1:0] line;
  int         rx_cnt [2] = '{-1, -1};
  logic [7:0] rx_sh  [2];
  int         frame_err = 0;
  assign line = {tx_s, tx};

  always @(negedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (rst_q !== 1'b1) begin
        rx_cnt[c] = -1;
      end else if (rx_cnt[c] < 0) begin
        if (line[c] === 1'b0) rx_cnt[c] = 0;
      end else begin
        rx_cnt[c] = rx_cnt[c] + 1;
        if (rx_cnt[c] % BD == BD / 2) begin
          if (rx_cnt[c] / BD == 0) begin
            if (line[c] !== 1'b0) frame_err++;
          end else if (rx_cnt[c] / BD <= 8) begin
            rx_sh[c][rx_cnt[c] / BD - 1] = line[c];
          end else begin
            if (line[c] !== 1'b1) frame_err++;
            if (c == 0) got_q.push_back(rx_sh[c]);
            else        got_s_q.push_back(rx_sh[c]);
            rx_cnt[c] = -1;
          end
        end
      end
    end
  end

  // busy / done activity counters for the main instance
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_busy_err = 0;
  always @(negedge clock) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (done === 1'b1 && busy !== 1'b0) done_busy_err++;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_seq = 0;
  int model_seq_s = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet model: preamble, sequence number, payload, byte sum mod 256.
  task automatic build_expected(input bit sec);
    int n;
    int sum;
    logic [7:0] b;
    n = sec ? 1 : PB;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(sec ? model_seq_s : model_seq));
    sum = 0;
    for (int i = 0; i < n; i++) begin
      b = sec ? ram_s : ram[i];
      exp_q.push_back(b);
      sum = (sum + int'(b)) % 256;
    end
    exp_q.push_back(8'(sum));
  endtask

  task automatic check_packet(input string tag, input bit sec, input int base);
    int ng;
    logic [7:0] g;
    ng = (sec ? got_s_q.size() : got_q.size()) - base;
    chk({tag, "_nbytes"}, ng, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 8'hxx;
      if (i < ng) g = sec ? got_s_q[base + i] : got_q[base + i];
      chk($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
  endtask

  // driver: wait (bounded) for a done pulse, returns at that negedge
  task automatic wait_done(input bit sec, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((sec ? done_s : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // driver: one RDY pulse on the main instance and a full packet check
  task automatic run_main(input string tag);
    bit ok;
    int b0, d0, g0;
    build_expected(1'b0);
    b0 = busy_cnt; d0 = done_cnt; g0 = got_q.size();
    rdy = 1'b1;
    @(negedge clock);
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    chk({tag, "_tx_start"}, 32'(tx), 32'd0);
    rdy = 1'b0;
    wait_done(1'b0, 2 * PKT_CLKS, ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clock);
    chk({tag, "_done_width"}, done_cnt - d0, 32'd1);
    chk({tag, "_busy_len"}, busy_cnt - b0, PKT_CLKS);
    check_packet(tag, 1'b0, g0);
    model_seq = (model_seq + 1) % 256;
  endtask

  initial begin
    bit ok;
    int b0, d0, g0;

    // reset
    reset = 1'b0; rdy = 1'b0; rdy_s = 1'b0; ram_s = 8'h00;
    foreach (ram[i]) ram[i] = 8'h00;
    repeat (3) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rdaddress", 32'(rdaddress), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // basic packet, then checksum wrap with the second sequence number
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'h04;
    run_main("basic");
    ram[0] = 8'hFF; ram[1] = 8'hFF; ram[2] = 8'h02; ram[3] = 8'h00;
    run_main("csum_wrap");

    // random payloads
    for (int r = 0; r < 3; r++) begin
      foreach (ram[i]) ram[i] = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 5)) @(negedge clock);
      run_main($sformatf("rand%0d", r));
    end
    chk("overrun_clear", 32'(overrun), 32'd0);

    // second RDY pulse 100 clocks into a packet
    foreach (ram[i]) ram[i] = 8'($urandom_range(0, 255));
    build_expected(1'b0);
    b0 = busy_cnt; d0 = done_cnt; g0 = got_q.size();
    rdy = 1'b1; @(negedge clock); rdy = 1'b0;
    repeat (99) @(negedge clock);
    rdy = 1'b1; @(negedge clock); rdy = 1'b0;
    chk("ovr_flag_set", 32'(overrun), 32'd1);
    wait_done(1'b0, 2 * PKT_CLKS, ok);
    chk("ovr_done_seen", 32'(ok), 32'd1);
    @(negedge clock);
    chk("ovr_busy_len", busy_cnt - b0, PKT_CLKS);
    chk("ovr_done_cnt", done_cnt - d0, 32'd1);
    check_packet("ovr", 1'b0, g0);
    model_seq = (model_seq + 1) % 256;
    b0 = busy_cnt; g0 = got_q.size();
    repeat (400) @(negedge clock);
    chk("ovr_no_second_busy", busy_cnt - b0, 32'd0);
    chk("ovr_no_second_bytes", got_q.size() - g0, 32'd0);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // RDY held high for 1000 clocks
    foreach (ram[i]) ram[i] = 8'($urandom_range(0, 255));
    build_expected(1'b0);
    b0 = busy_cnt; d0 = done_cnt; g0 = got_q.size();
    rdy = 1'b1;
    repeat (1000) @(negedge clock);
    rdy = 1'b0;
    @(negedge clock);
    chk("hold_done_cnt", done_cnt - d0, 32'd1);
    chk("hold_busy_len", busy_cnt - b0, PKT_CLKS);
    check_packet("hold", 1'b0, g0);
    model_seq = (model_seq + 1) % 256;
    chk("hold_ovr_sticky", 32'(overrun), 32'd1);

    // reset at clock 150 of a packet, with RDY high across reset release
    rdy = 1'b1; @(negedge clock); rdy = 1'b0;
    repeat (149) @(negedge clock);
    reset = 1'b0; rdy = 1'b1;
    @(negedge clock);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    chk("abort_rdaddress", 32'(rdaddress), 32'd0);
    chk("abort_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b1;
    model_seq = 0; model_seq_s = 0;
    b0 = busy_cnt;
    repeat (20) @(negedge clock);
    chk("rel_rdy_high_ignored", busy_cnt - b0, 32'd0);
    rdy = 1'b0;
    @(negedge clock);
    foreach (ram[i]) ram[i] = 8'($urandom_range(0, 255));
    run_main("post_reset");

    // 257 packets on the 1-byte instance: SEQ 00..FF then 00, each RDY
    // edge placed in the first IDLE clock after DONE
    ram_s = 8'($urandom_range(0, 255));
    for (int p = 0; p < 257; p++) begin
      build_expected(1'b1);
      g0 = got_s_q.size();
      rdy_s = 1'b1; @(negedge clock); rdy_s = 1'b0;
      wait_done(1'b1, 2 * PKT_CLKS_S, ok);
      chk($sformatf("wrap%0d_done_seen", p), 32'(ok), 32'd1);
      @(negedge clock);
      check_packet($sformatf("wrap%0d", p), 1'b1, g0);
      model_seq_s = (model_seq_s + 1) % 256;
    end
    chk("wrap_no_overrun", 32'(overrun_s), 32'd0);

    chk("frame_errors", frame_err, 32'd0);
    chk("done_with_busy", done_busy_err, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
